burst_line_adaptor: RTL and testbench

- Parametrised cacheline-to-burst converter between the cache's line-wide memory port and the physical-memory burst port.
- Assembles BEATS = LINE_WIDTH/BURST_WIDTH read beats into one line, and serialises one line into BEATS write beats.
- Tolerates gaps between memory beat responses.
- Sits between the cache/arbiter and physical memory; one outstanding transaction at a time.

---
 rtl/burst_line_adaptor_if.sv | 31 +++
 rtl/burst_line_adaptor.sv | 104 ++++++++++
 tb/tb_burst_line_adaptor.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/burst_line_adaptor_if.sv
// burst_line_adaptor_if: cache line port and physical-memory burst port seen by the adaptor.
// slave is the adaptor's view; master is the cache/memory environment's view.
interface burst_line_adaptor_if #(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BURST_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH  = 32
);
    logic                   ca_read;
    logic                   ca_write;
    logic [ADDR_WIDTH-1:0]  ca_address;
    logic [LINE_WIDTH-1:0]  ca_wdata;
    logic [LINE_WIDTH-1:0]  ca_rdata;
    logic                   ca_resp;
    logic                   ca_err;
    logic                   pmem_read;
    logic                   pmem_write;
    logic [ADDR_WIDTH-1:0]  pmem_address;
    logic [BURST_WIDTH-1:0] pmem_wdata;
    logic [BURST_WIDTH-1:0] pmem_rdata;
    logic                   pmem_resp;

    modport slave (
        input  ca_read, ca_write, ca_address, ca_wdata, pmem_rdata, pmem_resp,
        output ca_rdata, ca_resp, ca_err, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output ca_read, ca_write, ca_address, ca_wdata, pmem_rdata, pmem_resp,
        input  ca_rdata, ca_resp, ca_err, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/burst_line_adaptor.sv
// burst_line_adaptor: turns line-wide cache reads/writes into BEATS-long memory bursts.
// Define BURST_LINE_ADAPTOR_TIMEOUT_EN to add an inter-beat watchdog that aborts with ca_err.
module burst_line_adaptor #(
    parameter int unsigned LINE_WIDTH     = 256,
    parameter int unsigned BURST_WIDTH    = 64,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    burst_line_adaptor_if.slave  bus
);
    localparam int unsigned BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned CW    = $clog2(BEATS);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

    if (BEATS < 2 || LINE_WIDTH != BEATS * BURST_WIDTH || (BEATS & (BEATS - 1)) != 0 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("burst_line_adaptor: unsupported parameter combination");
    end

    typedef enum logic [2:0] {IDLE, RBURST, WBURST, DONE, ABORT} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic                  burst;

    assign burst = state_q == RBURST || state_q == WBURST;

`ifdef BURST_LINE_ADAPTOR_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          expired;
    assign expired = burst && !bus.pmem_resp && wd_q == WW'(TIMEOUT_CYCLES - 1);
    assign wd_d    = (burst && !bus.pmem_resp) ? wd_q + 1'b1 : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        line_d  = line_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.ca_read || bus.ca_write) begin
                    addr_d  = bus.ca_address & LINE_MASK;
                    state_d = bus.ca_read ? RBURST : WBURST;
                end
                if (!bus.ca_read && bus.ca_write) line_d = bus.ca_wdata;
            end
            RBURST, WBURST: if (bus.pmem_resp) begin
                cnt_d = cnt_q + 1'b1;
                if (state_q == RBURST) rdata_d[cnt_q*BURST_WIDTH +: BURST_WIDTH] = bus.pmem_rdata;
                if (cnt_q == CW'(BEATS - 1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
`ifdef BURST_LINE_ADAPTOR_TIMEOUT_EN
        if (expired) state_d = ABORT;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        bus.pmem_read    = state_q == RBURST;
        bus.pmem_write   = state_q == WBURST;
        bus.ca_resp      = state_q == DONE;
        bus.pmem_address = addr_q;
        bus.pmem_wdata   = state_q == WBURST ? line_q[cnt_q*BURST_WIDTH +: BURST_WIDTH] : '0;
        bus.ca_rdata     = rdata_q;
`ifdef BURST_LINE_ADAPTOR_TIMEOUT_EN
        bus.ca_err       = state_q == ABORT;
`else
        bus.ca_err       = 1'b0;
`endif
    end
endmodule

// File: tb/tb_burst_line_adaptor.sv
// tb_burst_line_adaptor: randomized line read/write transactions against a beat-level memory model.
module tb_burst_line_adaptor;
    localparam int LW = 256, BW = 64, AW = 32, NB = LW / BW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vec = 0, errs = 0;

    burst_line_adaptor_if #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) bus();

    burst_line_adaptor #(
        .LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got hang, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] line_addr(input logic [AW-1:0] a);
        return {a[AW-1:5], 5'b0};
    endfunction

    task automatic test_reset();
        bus.ca_read = 0; bus.ca_write = 0; bus.ca_address = '0; bus.ca_wdata = '0;
        bus.pmem_resp = 0; bus.pmem_rdata = '0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        vec++;
        if ({bus.ca_rdata, bus.ca_resp, bus.ca_err, bus.pmem_read, bus.pmem_write,
             bus.pmem_address, bus.pmem_wdata} !== '0)
            begin errs++; $display("FAIL reset_outputs: got %h required 0", {bus.ca_rdata, bus.ca_resp,
                bus.ca_err, bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata}); end
        bus.pmem_resp = 1;
        rst_n = 1;
        tick();
        vec++;
        if ({bus.ca_resp, bus.pmem_read, bus.pmem_write} !== 3'b000)
            begin errs++; $display("FAIL idle_strobes: got %b required 000",
                {bus.ca_resp, bus.pmem_read, bus.pmem_write}); end
        bus.pmem_resp = 0;
    endtask

    task automatic test_read(input logic [AW-1:0] addr, input logic [LW-1:0] line, input int gap_pct);
        int  k = 0, cyc = 1, gaps = 0;
        bit  done = 0;
        bus.ca_read = 1; bus.ca_address = addr; bus.pmem_resp = 1'($urandom);
        while (!done && cyc < 300) begin
            tick();
            cyc++;
            bus.ca_address = $urandom;
            if (bus.ca_resp) begin
                done = 1; bus.ca_read = 0; bus.pmem_resp = 1;
                vec++;
                if (bus.ca_rdata !== line)
                    begin errs++; $display("FAIL read_line: got %h required %h", bus.ca_rdata, line); end
                vec++;
                if (k != NB || bus.ca_err !== 1'b0)
                    begin errs++; $display("FAIL read_beats: got %0d beats err %b required %0d err 0", k, bus.ca_err, NB); end
                vec++;
                if (cyc != 2 + NB + gaps)
                    begin errs++; $display("FAIL read_latency: got %0d required %0d", cyc, 2 + NB + gaps); end
            end else if (bus.pmem_read) begin
                vec++;
                if (bus.pmem_address !== line_addr(addr) || bus.pmem_write !== 1'b0)
                    begin errs++; $display("FAIL read_addr: got %h wr %b required %h wr 0",
                        bus.pmem_address, bus.pmem_write, line_addr(addr)); end
                bus.pmem_resp  = k < NB && $urandom_range(99) >= gap_pct;
                bus.pmem_rdata = bus.pmem_resp ? line[k*BW +: BW] : {$urandom, $urandom};
                if (bus.pmem_resp) k++; else gaps++;
            end else begin
                bus.pmem_resp = 0;
            end
        end
        vec++;
        if (!done) begin errs++; $display("FAIL read_timeout: got no ca_resp required ca_resp"); end
        tick();
        bus.pmem_resp = 0;
        vec++;
        if ({bus.ca_resp, bus.pmem_read, bus.pmem_write} !== 3'b000)
            begin errs++; $display("FAIL read_resp_pulse: got %b required 000",
                {bus.ca_resp, bus.pmem_read, bus.pmem_write}); end
    endtask

    task automatic test_write(input logic [AW-1:0] addr, input logic [LW-1:0] line, input int fixed_gap);
        int  k = 0, cyc = 1, gaps = 0, g = 0;
        bit  done = 0;
        bus.ca_write = 1; bus.ca_address = addr; bus.ca_wdata = line; bus.pmem_resp = 1'($urandom);
        while (!done && cyc < 300) begin
            tick();
            cyc++;
            bus.ca_address = $urandom;
            bus.ca_wdata = rnd_line();
            if (bus.ca_resp) begin
                done = 1; bus.ca_write = 0; bus.pmem_resp = 1;
                vec++;
                if (k != NB || bus.ca_err !== 1'b0)
                    begin errs++; $display("FAIL write_beats: got %0d beats err %b required %0d err 0", k, bus.ca_err, NB); end
                vec++;
                if (cyc != 2 + NB + gaps)
                    begin errs++; $display("FAIL write_latency: got %0d required %0d", cyc, 2 + NB + gaps); end
            end else if (bus.pmem_write) begin
                vec++;
                if (k < NB && (bus.pmem_wdata !== line[k*BW +: BW] || bus.pmem_address !== line_addr(addr) ||
                    bus.pmem_read !== 1'b0))
                    begin errs++; $display("FAIL write_beat%0d: got %h @%h required %h @%h", k,
                        bus.pmem_wdata, bus.pmem_address, line[k*BW +: BW], line_addr(addr)); end
                bus.pmem_resp = k < NB && (fixed_gap >= 0 ? g == fixed_gap : $urandom_range(99) >= 30);
                bus.pmem_rdata = {$urandom, $urandom};
                if (bus.pmem_resp) begin k++; g = 0; end else begin gaps++; g++; end
            end else begin
                vec++;
                errs++; $display("FAIL write_strobe: got pmem_write 0 mid-transaction required 1");
                bus.pmem_resp = 0;
            end
        end
        vec++;
        if (!done) begin errs++; $display("FAIL write_timeout: got no ca_resp required ca_resp"); end
        tick();
        bus.pmem_resp = 0;
        vec++;
        if ({bus.ca_resp, bus.pmem_read, bus.pmem_write} !== 3'b000)
            begin errs++; $display("FAIL write_resp_pulse: got %b required 000",
                {bus.ca_resp, bus.pmem_read, bus.pmem_write}); end
    endtask

    task automatic test_both();
        logic [LW-1:0] rl = rnd_line(), wl = rnd_line();
        logic [AW-1:0] ra = $urandom;
        int  k = 0, ph = 0, resps = 0;
        bit  done = 0;
        bus.ca_read = 1; bus.ca_write = 1; bus.ca_address = ra; bus.ca_wdata = wl;
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            bus.pmem_resp = 0;
            if (bus.ca_resp) begin
                resps++;
                vec++;
                if (k != NB) begin errs++; $display("FAIL both_beats: got %0d required %0d", k, NB); end
                if (ph == 0) begin
                    vec++;
                    if (bus.ca_rdata !== rl)
                        begin errs++; $display("FAIL both_read_line: got %h required %h", bus.ca_rdata, rl); end
                    bus.ca_read = 0; ph = 1; k = 0;
                end else begin
                    done = 1; bus.ca_write = 0;
                end
            end else if (bus.pmem_read || bus.pmem_write) begin
                vec++;
                if (bus.pmem_read !== (ph == 0) || bus.pmem_write !== (ph == 1))
                    begin errs++; $display("FAIL both_order: got rd %b wr %b required phase %0d", bus.pmem_read, bus.pmem_write, ph); end
                if (bus.pmem_write) begin
                    vec++;
                    if (k < NB && bus.pmem_wdata !== wl[k*BW +: BW])
                        begin errs++; $display("FAIL both_wdata%0d: got %h required %h", k, bus.pmem_wdata, wl[k*BW +: BW]); end
                end
                bus.pmem_resp = k < NB && $urandom_range(3) != 0;
                bus.pmem_rdata = rl[(k % NB)*BW +: BW];
                if (bus.pmem_resp) k++;
            end
        end
        vec++;
        if (!done || resps != 2) begin errs++; $display("FAIL both_complete: got %0d resps required 2", resps); end
        tick();
        vec++;
        if ({bus.ca_resp, bus.pmem_read, bus.pmem_write} !== 3'b000)
            begin errs++; $display("FAIL both_idle: got %b required 000", {bus.ca_resp, bus.pmem_read, bus.pmem_write}); end
    endtask

    task automatic test_reset_mid();
        logic [LW-1:0] line = rnd_line();
        int  k = 0;
        bit  hit = 0;
        bus.ca_read = 1; bus.ca_address = $urandom;
        for (int c = 0; c < 50 && !hit; c++) begin
            tick();
            if (bus.pmem_read && k == 2) begin
                hit = 1;
                rst_n = 0;
                #1;
                vec++;
                if ({bus.ca_rdata, bus.ca_resp, bus.ca_err, bus.pmem_read, bus.pmem_write,
                     bus.pmem_address, bus.pmem_wdata} !== '0)
                    begin errs++; $display("FAIL reset_mid_outputs: got %h required 0", {bus.ca_rdata, bus.ca_resp,
                        bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata}); end
            end else if (bus.pmem_read) begin
                bus.pmem_resp = 1; bus.pmem_rdata = line[k*BW +: BW]; k++;
            end
        end
        vec++;
        if (!hit) begin errs++; $display("FAIL reset_mid_reach: got %0d beats required 2", k); end
        bus.ca_read = 0; bus.pmem_resp = 0;
        tick();
        tick();
        rst_n = 1;
        for (int c = 0; c < 6; c++) begin
            tick();
            vec++;
            if ({bus.ca_resp, bus.pmem_read} !== 2'b00)
                begin errs++; $display("FAIL reset_mid_no_resp: got %b required 00", {bus.ca_resp, bus.pmem_read}); end
        end
        test_read($urandom, rnd_line(), 20);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(1) == 1) test_read($urandom, rnd_line(), int'($urandom_range(60)));
            else test_write($urandom, rnd_line(), $urandom_range(1) == 1 ? -1 : int'($urandom_range(3)));
        end
    endtask

    initial begin
        test_reset();
        test_read(32'h0000_1234, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0);
        test_write($urandom, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 2);
        test_both();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
